active_pixel_ctrl: RTL and testbench
====================================

Name: active_pixel_ctrl

Overview:
- Ping-pong sequencer for the two-bank active-pixel bit memory (512x1 per bank; bank select input, 1-cycle registered read).
- Accepts one line of active-pixel flags from the loader over a valid/ready stream and fills the back bank.
- On each line-start from the timing core, swaps banks and scans the front bank one flag per pixel enable.
- Sole owner of waddr/wdata/wen/mem_selector/raddr on the memory; reports underrun/overrun.

Parameters:
- ADDR_W, 9, memory address width.
- LINE_LEN, 512, flags per line; must satisfy 2 <= LINE_LEN <= 2**ADDR_W.

Ports:
- clk_i  in  1  single clock for everything.
- rstn_i  in  1  synchronous reset, active-low.
- wr_data_i  in  1  active-pixel flag from loader.
- wr_valid_i  in  1  loader flag valid.
- wr_ready_o  out  1  controller can accept a flag.
- line_start_i  in  1  one-cycle pulse from timing core: start of line.
- pixel_en_i  in  1  pixel-rate enable during scan.
- clr_status_i  in  1  clears sticky flags.
- waddr_o  out  ADDR_W  memory write address.
- wdata_o  out  1  memory write data.
- wen_o  out  1  memory write enable.
- mem_selector_o  out  1  bank select (1: write bank1/read bank0; 0: write bank0/read bank1).
- raddr_o  out  ADDR_W  memory read address.
- active_pixel_i  in  1  memory read data, valid 1 cycle after raddr_o.
- pixel_o  out  1  scanned active-pixel flag.
- pixel_valid_o  out  1  pixel_o qualifier.
- line_done_o  out  1  pulse with the last pixel_valid_o of a line.
- underrun_o  out  1  sticky: line_start with back bank not full.
- overrun_o  out  1  sticky: line_start during an active scan.

Behaviour:
- Reset (rstn_i=0 at a clock edge): write FSM W_FILL with wr_cnt=0; read FSM R_IDLE with rd_cnt=0; mem_selector_o=0; rd_bank_valid=0; pixel_o=0, pixel_valid_o=0, line_done_o=0, underrun_o=0, overrun_o=0, raddr_o=0. Reset mid-line drops partial fill and scan.
- Write path (combinational, so a write lands with the selector in force that cycle):
  - wr_ready_o = (wstate==W_FILL).
  - wen_o = wr_valid_i & wr_ready_o; waddr_o = wr_cnt; wdata_o = wr_data_i.
  - Per handshake wr_cnt++. The handshake at wr_cnt==LINE_LEN-1 moves to W_DONE, wr_cnt=0.
- W_DONE holds wr_ready_o=0 until a swap.
- Swap, decided at line_start_i edge T:
  - If W_DONE, or the final fill handshake occurs in the same cycle T: from T+1, mem_selector_o toggled, rd_bank_valid=1, wstate=W_FILL.
  - Otherwise no toggle; underrun_o<=1; partial fill continues; the old front bank is rescanned.
- Read FSM:
  - Any line_start_i enters R_SCAN at T+1 with rd_cnt=0, raddr_o=0.
  - In R_SCAN, each cycle with pixel_en_i=1 consumes raddr_o and then increments it.
  - Consuming LINE_LEN-1 returns to R_IDLE, raddr_o=0.
  - line_start_i while in R_SCAN: overrun_o<=1, scan restarts at 0 (swap rules above still apply).
- Output: the cycle after each consume, pixel_valid_o=1 and pixel_o = active_pixel_i & rd_bank_valid. line_done_o=1 on the cycle for address LINE_LEN-1.
- pixel_en_i outside R_SCAN is ignored.
- Sticky flags: clr_status_i clears both; a set in the same cycle wins.
- Latency: line_start to first pixel_valid_o is 2 cycles minimum (pixel_en_i held high).

Decomposition:
- Package active_pixel_pkg holds:
  - wstate enum {W_FILL, W_DONE} and rstate enum {R_IDLE, R_SCAN}.
  - Default ADDR_W, LINE_LEN constants.
- One natural sub-module: active_pixel_rd_scan (read FSM, rd_cnt, valid/last pipeline stage).
- Write FSM and swap logic stay in the top.

Test Plan:
- LINE_LEN=4; fill 1,0,1,1; line_start -> mem_selector_o 0->1 at T+1; with pixel_en_i high, pixel_o=1,0,1,1 on T+2..T+5; line_done_o at T+5.
- Line_start right after reset, no fill -> no swap, underrun_o=1; 4 pixel_valid_o with pixel_o=0 (rd_bank_valid=0).
- Fill only 2 flags, then line_start -> selector unchanged, underrun_o=1, wr_ready_o stays 1; after 2 more writes wstate=W_DONE and wr_ready_o=0.
- Final fill handshake and line_start in the same cycle -> that write lands in the old back bank (wen_o with old selector); selector toggles at T+1; new line read back intact.
- Second line_start while scan is at rd_cnt=2 -> overrun_o=1; raddr_o restarts at 0; clr_status_i pulse clears the flag.
- Assert rstn_i=0 mid-fill and mid-scan -> next cycle all outputs at reset values, mem_selector_o=0, wr_ready_o=1.

Source files
------------

// File: rtl/active_pixel_pkg.sv
// Shared types and default geometry for the active-pixel ping-pong sequencer.
package active_pixel_pkg;
  localparam int ADDR_W_DEF   = 9;
  localparam int LINE_LEN_DEF = 512;

  typedef enum logic {W_FILL, W_DONE} wstate_e;
  typedef enum logic {R_IDLE, R_SCAN} rstate_e;
endpackage

// File: rtl/active_pixel_rd_scan.sv
// Front-bank scanner: walks the read address on pixel enables and registers
// the valid/last qualifiers that line up with the 1-cycle memory read.
module active_pixel_rd_scan
  import active_pixel_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              line_start_i,
  input  logic              pixel_en_i,
  input  logic              active_pixel_i,
  input  logic              bank_valid_i,
  output logic [ADDR_W-1:0] raddr_o,
  output logic              scanning_o,
  output logic              pixel_o,
  output logic              pixel_valid_o,
  output logic              line_done_o
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

  rstate_e           rstate_q;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic              valid_q;
  logic              last_q;
  logic              consume;

  assign consume = (rstate_q == R_SCAN) && pixel_en_i;

  // A line start always wins over a consume: the scan restarts from address 0.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rstate_q <= R_IDLE;
      rd_cnt_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      valid_q <= consume;
      last_q  <= consume && (rd_cnt_q == LAST_ADDR);
      if (line_start_i) begin
        rstate_q <= R_SCAN;
        rd_cnt_q <= '0;
      end else if (consume) begin
        if (rd_cnt_q == LAST_ADDR) begin
          rstate_q <= R_IDLE;
          rd_cnt_q <= '0;
        end else begin
          rd_cnt_q <= rd_cnt_q + 1'b1;
        end
      end
    end
  end

  assign raddr_o       = rd_cnt_q;
  assign scanning_o    = (rstate_q == R_SCAN);
  assign pixel_valid_o = valid_q;
  assign line_done_o   = last_q;
  assign pixel_o       = valid_q & active_pixel_i & bank_valid_i;
endmodule

// File: rtl/active_pixel_ctrl.sv
// Ping-pong controller for the two-bank active-pixel memory: fills the back
// bank from the loader stream, swaps on line start and scans the front bank.
module active_pixel_ctrl
  import active_pixel_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic              line_start_i,
  input  logic              pixel_en_i,
  input  logic              clr_status_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              wdata_o,
  output logic              wen_o,
  output logic              mem_selector_o,
  output logic [ADDR_W-1:0] raddr_o,
  input  logic              active_pixel_i,
  output logic              pixel_o,
  output logic              pixel_valid_o,
  output logic              line_done_o,
  output logic              underrun_o,
  output logic              overrun_o
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

  wstate_e           wstate_q, wstate_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              sel_q, sel_d;
  logic              bank_valid_q, bank_valid_d;
  logic              under_q, under_d;
  logic              over_q, over_d;
  logic              wr_hs, wr_final, scanning;
  logic              under_set, over_set;

  // Combinational write path so each write uses the selector of its own cycle.
  assign wr_ready_o = (wstate_q == W_FILL);
  assign wen_o      = wr_valid_i & wr_ready_o;
  assign waddr_o    = wr_cnt_q;
  assign wdata_o    = wr_data_i;
  assign wr_hs      = wen_o;
  assign wr_final   = wr_hs && (wr_cnt_q == LAST_ADDR);

  always_comb begin
    wstate_d     = wstate_q;
    wr_cnt_d     = wr_cnt_q;
    sel_d        = sel_q;
    bank_valid_d = bank_valid_q;
    under_set    = 1'b0;
    over_set     = line_start_i & scanning;
    if (wr_hs) begin
      if (wr_final) begin
        wstate_d = W_DONE;
        wr_cnt_d = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    // A line completed in the very cycle of line start still counts as full.
    if (line_start_i) begin
      if ((wstate_q == W_DONE) || wr_final) begin
        sel_d        = ~sel_q;
        bank_valid_d = 1'b1;
        wstate_d     = W_FILL;
        wr_cnt_d     = '0;
      end else begin
        under_set = 1'b1;
      end
    end
    under_d = under_set | (under_q & ~clr_status_i);
    over_d  = over_set  | (over_q  & ~clr_status_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wstate_q     <= W_FILL;
      wr_cnt_q     <= '0;
      sel_q        <= 1'b0;
      bank_valid_q <= 1'b0;
      under_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      wstate_q     <= wstate_d;
      wr_cnt_q     <= wr_cnt_d;
      sel_q        <= sel_d;
      bank_valid_q <= bank_valid_d;
      under_q      <= under_d;
      over_q       <= over_d;
    end
  end

  assign mem_selector_o = sel_q;
  assign underrun_o     = under_q;
  assign overrun_o      = over_q;

  active_pixel_rd_scan #(
    .ADDR_W  (ADDR_W),
    .LINE_LEN(LINE_LEN)
  ) u_rd_scan (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .line_start_i  (line_start_i),
    .pixel_en_i    (pixel_en_i),
    .active_pixel_i(active_pixel_i),
    .bank_valid_i  (bank_valid_q),
    .raddr_o       (raddr_o),
    .scanning_o    (scanning),
    .pixel_o       (pixel_o),
    .pixel_valid_o (pixel_valid_o),
    .line_done_o   (line_done_o)
  );
endmodule

// File: tb/tb_active_pixel_ctrl.sv
// Directed and random stimulus for active_pixel_ctrl against a line-level model.
module tb_active_pixel_ctrl;
  localparam int AW = 9;
  localparam int L  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, wr_data, wr_valid, line_start, pixel_en, clr;
  logic wr_ready, wen, wdata, sel, pixel, pv, ldone, under, over, active_pixel;
  logic [AW-1:0] waddr, raddr;

  active_pixel_ctrl #(.ADDR_W(AW), .LINE_LEN(L)) dut (
    .clk_i(clk), .rstn_i(rstn), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .line_start_i(line_start), .pixel_en_i(pixel_en),
    .clr_status_i(clr), .waddr_o(waddr), .wdata_o(wdata), .wen_o(wen),
    .mem_selector_o(sel), .raddr_o(raddr), .active_pixel_i(active_pixel),
    .pixel_o(pixel), .pixel_valid_o(pv), .line_done_o(ldone),
    .underrun_o(under), .overrun_o(over)
  );

  // Two-bank 512x1 memory with registered read, driven only by the DUT.
  logic mem [2][0:(1<<AW)-1];
  logic rd_q;
  assign active_pixel = rd_q;
  always @(posedge clk) begin
    if (wen) mem[sel][waddr] <= wdata;
    rd_q <= mem[!sel][raddr];
  end

  // Reference state: contents of each bank as the specification routes writes.
  bit m_bank [2][L];
  int m_fill, m_pos;
  bit m_done, m_sel, m_fv, m_scan, m_under, m_over, m_pv, m_pdata, m_last;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input bit r, v, d, ls, pe, c);
    bit hs, fin, cons, done_old, su, so;
    if (!r) begin
      m_fill = 0; m_pos = 0; m_done = 0; m_sel = 0; m_fv = 0; m_scan = 0;
      m_under = 0; m_over = 0; m_pv = 0; m_pdata = 0; m_last = 0;
      return;
    end
    done_old = m_done;
    hs   = v && !m_done;
    fin  = hs && (m_fill == L - 1);
    cons = m_scan && pe;
    m_pv    = cons;
    m_pdata = m_bank[m_sel ? 0 : 1][m_pos];
    m_last  = cons && (m_pos == L - 1);
    if (hs) begin
      m_bank[m_sel ? 1 : 0][m_fill] = d;
      if (fin) begin m_done = 1; m_fill = 0; end
      else m_fill++;
    end
    so = ls && m_scan;
    su = 0;
    if (ls) begin
      m_scan = 1; m_pos = 0;
    end else if (cons) begin
      if (m_pos == L - 1) begin m_scan = 0; m_pos = 0; end
      else m_pos++;
    end
    if (ls) begin
      if (done_old || fin) begin
        m_sel = !m_sel; m_fv = 1; m_done = 0; m_fill = 0;
      end else su = 1;
    end
    m_under = su | (m_under & !c);
    m_over  = so | (m_over & !c);
  endtask

  task automatic step(input bit r, v, d, ls, pe, c, input bit do_chk = 1);
    rstn = r; wr_valid = v; wr_data = d; line_start = ls; pixel_en = pe; clr = c;
    @(negedge clk);
    if (do_chk) begin
      chk("wr_ready", wr_ready, !m_done);
      chk("wen", wen, v && !m_done);
      chk("waddr", waddr, m_fill);
      chk("wdata", wdata, d);
      chk("mem_selector", sel, m_sel);
      chk("raddr", raddr, m_pos);
      chk("underrun", under, m_under);
      chk("overrun", over, m_over);
      chk("pixel_valid", pv, m_pv);
      chk("line_done", ldone, m_last);
      if (m_pv) chk("pixel", pixel, m_pdata & m_fv);
      if (!r) begin end
    end
    @(posedge clk);
    model_update(r, v, d, ls, pe, c);
    #1;
  endtask

  task automatic fill(input int n, input logic [3:0] bits);
    for (int i = 0; i < n; i++) step(1, 1, bits[i], 0, 0, 0);
  endtask

  task automatic run(input int n, input bit pe);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, pe, 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < (1 << AW); a++) mem[b][a] = 1'b0;
    rd_q = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Line start with nothing filled: underrun, front bank not yet valid.
    step(1, 0, 0, 1, 1, 0);
    run(5, 1);
    step(1, 0, 0, 0, 0, 1);
    // Full line 1,0,1,1 then swap and scan.
    fill(4, 4'b1101);
    step(1, 0, 0, 1, 1, 0);
    run(6, 1);
    // Partial fill, early line start, then completion.
    fill(2, 4'b0001);
    step(1, 0, 0, 1, 1, 0);
    run(2, 1);
    fill(2, 4'b0011);
    run(3, 1);
    step(1, 0, 0, 1, 1, 1);
    run(5, 1);
    // Final handshake coincides with line start.
    fill(3, 4'b0011);
    step(1, 1, 1, 1, 1, 0);
    run(5, 1);
    // Overrun: second line start at rd_cnt == 2, then clear.
    fill(4, 4'b0110);
    step(1, 0, 0, 1, 1, 0);
    run(2, 1);
    step(1, 0, 0, 1, 1, 0);
    run(5, 1);
    step(1, 0, 0, 0, 0, 1);
    run(1, 0);
    // Reset mid-fill and mid-scan.
    fill(2, 4'b0011);
    step(0, 1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    fill(4, 4'b1010);
    step(1, 0, 0, 1, 1, 0);
    run(2, 1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    // Random traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 9) < 7, 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
